// File: rtl/nl_writeback_arbiter.sv
// Arbitrates the nonlinear-block write stream (buffered in a small FIFO) against
// MAC-array writes onto the single activation-memory write port; flags job completion.
module nl_writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_nonlinear_block,
  input  logic                  nl_wr_en,
  input  logic [ADDR_WIDTH-1:0] nl_wr_addr,
  input  logic [DATA_WIDTH-1:0] nl_wr_data,
  input  logic                  nl_finished_activation,
  input  logic                  array_wr_en,
  input  logic [ADDR_WIDTH-1:0] array_wr_addr,
  input  logic [DATA_WIDTH-1:0] array_wr_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  fifo_full,
  output logic                  fifo_overflow,
  output logic                  writeback_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               en_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic start, running, abort, flush;
  logic push_req, push, pop, drop;

  assign start    = enable_nonlinear_block & ~en_d;
  assign running  = (state == ACTIVE) || (state == DRAIN);
  assign abort    = running & ~enable_nonlinear_block;
  assign flush    = ((state == IDLE) & start) | abort;

  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign push_req  = nl_wr_en & running;
  assign pop       = (count != '0) & ~array_wr_en;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;

  assign writeback_done = (state == DONE);

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = ACTIVE;
      ACTIVE: begin
        if (!enable_nonlinear_block)     state_nxt = IDLE;
        else if (nl_finished_activation) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!enable_nonlinear_block)            state_nxt = IDLE;
        else if (count == '0 && !push && !pop)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      en_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      en_d  <= enable_nonlinear_block;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (!abort) fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) fifo_overflow <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      addr_mem[wr_ptr] <= nl_wr_addr;
      data_mem[wr_ptr] <= nl_wr_data;
    end
  end

  // Array writes always win; the FIFO head only moves on array-idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (array_wr_en) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= array_wr_addr;
      mem_wr_data <= array_wr_data;
    end else if (pop) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= addr_mem[rd_ptr];
      mem_wr_data <= data_mem[rd_ptr];
    end else begin
      mem_wr_en   <= 1'b0;
    end
  end

endmodule
